restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_step.sv | 31 +++
 rtl/restoring_divider.sv | 126 ++++++++++++
 tb/tb_restoring_divider.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the restoring divider.
// Revision    : 1.0
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DW_DEFAULT = 8;
    localparam int VW_DEFAULT = 4;

    // Iteration counter must hold DW-1.
    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(DW_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step on magnitudes.
// Revision    : 1.0
// ============================================================================
module div_step #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic [VW:0]   pr,
    input  logic [DW-1:0] q,
    input  logic [VW-1:0] d,
    output logic [VW:0]   pr_next,
    output logic [DW-1:0] q_next
);

    logic [VW+1:0] w_shift;
    logic [VW+1:0] w_trial;
    logic          w_neg;

    assign w_shift = {pr, q[DW-1]};
    assign w_trial = w_shift - {2'b00, d};
    assign w_neg   = (w_shift < {2'b00, d});

    // Partial remainder stays below the divisor magnitude, so VW+1 bits suffice.
    assign pr_next = (VW+1)'(w_neg ? w_shift : w_trial);
    assign q_next  = {q[DW-2:0], ~w_neg};

endmodule
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider
// Description : Signed sequential restoring divider (control FSM + sign fixup).
// Revision    : 1.0
// ============================================================================
module restoring_divider
    import div_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int VW = VW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz,
    output logic          ovf
);

    localparam int CW = cnt_width(DW);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [VW:0]   r_pr;
    logic [DW-1:0] r_q;
    logic [VW-1:0] r_dvs;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_ovf;

    logic [VW:0]   w_pr_next;
    logic [DW-1:0] w_q_next;
    logic          w_zero_div;
    logic          w_ovf_case;

    assign w_zero_div = (divisor == '0);
    assign w_ovf_case = (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);

    div_step #(.DW(DW), .VW(VW)) u_step (
        .pr      (r_pr),
        .q       (r_q),
        .d       (r_dvs),
        .pr_next (w_pr_next),
        .q_next  (w_q_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = w_zero_div ? DONE : CALC;
            CALC: if (r_cnt == '0) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_pr      <= '0;
            r_q       <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_ovf     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            busy <= (w_next == CALC) || (w_next == FIX);
            done <= (w_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start && w_zero_div) begin
                        quotient  <= '0;
                        remainder <= '0;
                        dbz       <= 1'b1;
                        ovf       <= 1'b0;
                    end else if (start) begin
                        // Magnitudes are unsigned, so -2^(N-1) still fits.
                        r_q     <= dividend[DW-1] ? -dividend : dividend;
                        r_dvs   <= divisor[VW-1]  ? -divisor  : divisor;
                        r_neg_q <= dividend[DW-1] ^ divisor[VW-1];
                        r_neg_r <= dividend[DW-1];
                        r_ovf   <= w_ovf_case;
                        r_pr    <= '0;
                        r_cnt   <= CW'(DW-1);
                    end
                end
                CALC: begin
                    r_pr <= w_pr_next;
                    r_q  <= w_q_next;
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                end
                FIX: begin
                    quotient  <= r_neg_q ? -r_q : r_q;
                    remainder <= r_neg_r ? -r_pr[VW-1:0] : r_pr[VW-1:0];
                    dbz       <= 1'b0;
                    ovf       <= r_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_restoring_divider
// Description : Self-checking bench: directed table, random model, corner cases.
// Revision    : 1.0
// ============================================================================
module tb_restoring_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dbz;
    logic          ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    restoring_divider #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dd;
        logic [VW-1:0] dv;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
        logic          o;
        int            lat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic; SV division truncates toward zero.
    task automatic model(input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                         output logic [DW-1:0] q, output logic [VW-1:0] r,
                         output logic z, output logic o, output int lat);
        int a, b, qi, ri;
        a = int'($signed(dd));
        b = int'($signed(dv));
        z = 1'b0; o = 1'b0; lat = DW + 2;
        if (b == 0) begin
            q = '0; r = '0; z = 1'b1; lat = 1;
        end else if (a == -(1 << (DW-1)) && b == -1) begin
            q = DW'(1 << (DW-1)); r = '0; o = 1'b1;
        end else begin
            qi = a / b;
            ri = a % b;
            q = DW'(qi);
            r = VW'(ri);
        end
    endtask

    // Issue one divide; lat counts clock edges from the accepting edge to done.
    task automatic run_div(input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                           output int lat, output logic pulse_ok);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        @(negedge clk);
        pulse_ok = ~done;
    endtask

    vec_t          tbl[6];
    int            lat;
    logic          pulse_ok;
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          ez, eo;
    int            elat;
    int            done_cnt;

    initial begin
        tbl[0] = '{8'd100,  4'd7,  8'h0E, 4'h2, 1'b0, 1'b0, 10};
        tbl[1] = '{8'h9C,   4'd7,  8'hF2, 4'hE, 1'b0, 1'b0, 10};
        tbl[2] = '{8'd100,  4'h9,  8'hF2, 4'h2, 1'b0, 1'b0, 10};
        tbl[3] = '{8'h80,   4'hF,  8'h80, 4'h0, 1'b0, 1'b1, 10};
        tbl[4] = '{8'h80,   4'h8,  8'h10, 4'h0, 1'b0, 1'b0, 10};
        tbl[5] = '{8'd5,    4'd0,  8'h00, 4'h0, 1'b1, 1'b0, 1};

        reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", dbz, 0);
        check("reset_ovf", ovf, 0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            run_div(tbl[i].dd, tbl[i].dv, lat, pulse_ok);
            check($sformatf("vec%0d_quotient", i), quotient, tbl[i].q);
            check($sformatf("vec%0d_remainder", i), remainder, tbl[i].r);
            check($sformatf("vec%0d_dbz", i), dbz, tbl[i].z);
            check($sformatf("vec%0d_ovf", i), ovf, tbl[i].o);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_single_pulse", i), pulse_ok, 1);
        end

        for (int i = 0; i < 60; i++) begin
            logic [DW-1:0] rdd;
            logic [VW-1:0] rdv;
            rdd = DW'($urandom_range(0, 255));
            rdv = (i % 8 == 0) ? '0 : VW'($urandom_range(0, 15));
            if (i == 5) begin rdd = 8'h80; rdv = 4'hF; end
            model(rdd, rdv, eq, er, ez, eo, elat);
            run_div(rdd, rdv, lat, pulse_ok);
            check($sformatf("rnd%0d_quotient(%0h/%0h)", i, rdd, rdv), quotient, eq);
            check($sformatf("rnd%0d_remainder(%0h/%0h)", i, rdd, rdv), remainder, er);
            check($sformatf("rnd%0d_dbz", i), dbz, ez);
            check($sformatf("rnd%0d_ovf", i), ovf, eo);
            check($sformatf("rnd%0d_latency", i), lat, elat);
        end

        // Reset during CALC cycle 4 aborts without a done pulse.
        @(negedge clk);
        dividend = 8'd100; divisor = 4'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midop_busy_before_reset", busy, 1);
        reset = 1'b0;
        #1;
        check("midop_busy_in_reset", busy, 0);
        check("midop_quotient_in_reset", quotient, 0);
        done_cnt = 0;
        repeat (2) begin @(negedge clk); if (done) done_cnt++; end
        reset = 1'b1;
        repeat (14) begin @(negedge clk); if (done) done_cnt++; end
        check("midop_no_done", done_cnt, 0);
        check("midop_idle_busy", busy, 0);
        run_div(8'd100, 4'd7, lat, pulse_ok);
        check("after_reset_quotient", quotient, 8'h0E);
        check("after_reset_remainder", remainder, 4'h2);
        check("after_reset_latency", lat, 10);

        // Start while busy is ignored.
        @(negedge clk);
        dividend = 8'd100; divisor = 4'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        @(negedge clk);
        dividend = 8'd50; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (done) begin
                // Start held across the DONE->IDLE edge is also ignored.
                dividend = 8'd50; divisor = 4'd3; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        check("busy_start_one_done", done_cnt, 1);
        check("busy_start_quotient", quotient, 8'h0E);
        check("busy_start_remainder", remainder, 4'h2);
        check("busy_start_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
